// File: rtl/npu_pkg.sv
// Shared NPU types and saturating arithmetic helpers.
// Helpers work on a 64-bit signed carrier and clamp to a runtime width w (w <= 62).
package npu_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} psum_state_e;

    localparam int unsigned SAT_W = 64;

    function automatic logic signed [SAT_W-1:0] sat_trunc(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             w
    );
        return sat_trunc(a + b, w);
    endfunction

endpackage

// File: rtl/psum_requant.sv
// Drain-side requantiser: bias add, optional ReLU, arithmetic shift, saturate to OUT_W_Q.
// Result and its address are registered when i_load is high.
module psum_requant
    import npu_pkg::*;
#(
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned OUT_W_Q = 8,
    parameter int unsigned AW      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_load,
    input  logic signed [ACC_W-1:0]   i_acc,
    input  logic        [AW-1:0]      i_addr,
    input  logic signed [ACC_W-1:0]   i_bias,
    input  logic                      i_relu,
    input  logic        [4:0]         i_shift,
    output logic signed [OUT_W_Q-1:0] o_data,
    output logic        [AW-1:0]      o_addr
);

    logic signed [SAT_W-1:0]   w_biased;
    logic signed [SAT_W-1:0]   w_relu;
    logic signed [SAT_W-1:0]   w_shifted;
    logic signed [OUT_W_Q-1:0] w_q;

    always_comb begin
        w_biased  = sat_add(SAT_W'(i_acc), SAT_W'(i_bias), ACC_W);
        w_relu    = (i_relu && (w_biased < 0)) ? '0 : w_biased;
        w_shifted = w_relu >>> i_shift;
        w_q       = OUT_W_Q'(sat_trunc(w_shifted, OUT_W_Q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_data <= '0;
            o_addr <= '0;
        end else if (i_load) begin
            o_data <= w_q;
            o_addr <= i_addr;
        end
    end

endmodule

// File: rtl/psum_accum_stream.sv
// Multi-channel partial-sum accumulator: sums conv pixels over cfg_num_ch channels into an
// OUT_H x OUT_W map, then drains bias/ReLU/requantised results as a valid/ready stream.
module psum_accum_stream
    import npu_pkg::*;
#(
    parameter int unsigned OUT_H   = 12,
    parameter int unsigned OUT_W   = 11,
    parameter int unsigned IN_W    = 24,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned OUT_W_Q = 8,
    parameter int unsigned MAX_CH  = 16,
    parameter int unsigned CH_W    = $clog2(MAX_CH + 1),
    parameter int unsigned AW      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic        [CH_W-1:0]    cfg_num_ch,
    input  logic signed [ACC_W-1:0]   cfg_bias,
    input  logic                      cfg_relu,
    input  logic        [4:0]         cfg_shift,
    input  logic                      in_valid,
    input  logic        [AW-1:0]      in_addr,
    input  logic signed [IN_W-1:0]    in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic        [AW-1:0]      out_addr,
    output logic signed [OUT_W_Q-1:0] out_data,
    output logic                      busy,
    output logic                      done,
    output logic        [CH_W-1:0]    ch_idx,
    output logic                      err
);

    localparam int unsigned    MAP       = OUT_H * OUT_W;
    localparam logic [AW-1:0]  LAST_ADDR = AW'(MAP - 1);
    localparam logic [AW:0]    MAP_END   = (AW + 1)'(MAP);

    psum_state_e r_state;
    psum_state_e w_state_nxt;

    logic signed [ACC_W-1:0] r_map [0:MAP-1];
    logic        [CH_W-1:0]  r_num_ch;
    logic        [CH_W-1:0]  r_ch_idx;
    logic signed [ACC_W-1:0] r_bias;
    logic                    r_relu;
    logic        [4:0]       r_shift;
    logic        [AW:0]      r_ptr;
    logic                    r_out_valid;
    logic                    r_done;
    logic                    r_err;

    logic                    w_start_ok;
    logic                    w_addr_ok;
    logic                    w_beat;
    logic                    w_last_addr;
    logic                    w_last_ch;
    logic                    w_accept;
    logic                    w_last_acc;
    logic                    w_load;
    logic                    w_ovf;
    logic                    w_err_evt;
    logic signed [ACC_W-1:0] w_old;
    logic signed [ACC_W-1:0] w_wr;
    logic signed [ACC_W-1:0] w_rd_acc;
    logic signed [SAT_W-1:0] w_raw;
    logic signed [SAT_W-1:0] w_sat;

    always_comb begin
        w_start_ok  = start && (r_state == IDLE);
        w_addr_ok   = in_addr < AW'(MAP);
        w_beat      = in_valid && (r_state == ACCUM) && w_addr_ok;
        w_last_addr = in_addr == LAST_ADDR;
        w_last_ch   = r_ch_idx == (r_num_ch - 1'b1);
        w_accept    = r_out_valid && out_ready;
        w_last_acc  = w_accept && (out_addr == LAST_ADDR);
        w_load      = (r_state == DRAIN) && (r_ptr < MAP_END) && (!r_out_valid || out_ready);
    end

    // Read-modify-write completes within the beat's cycle, so consecutive beats to the
    // same address always see the previous result without a separate bypass path.
    always_comb begin
        w_old = w_addr_ok ? r_map[in_addr] : '0;
        w_raw = SAT_W'(w_old) + SAT_W'(in_data);
        w_sat = sat_trunc(w_raw, ACC_W);
        w_ovf = (r_ch_idx != '0) && (w_sat != w_raw);
        w_wr  = (r_ch_idx == '0) ? ACC_W'(in_data) : w_sat[ACC_W-1:0];
    end

    assign w_rd_acc  = r_map[r_ptr[AW-1:0]];
    assign w_err_evt = (in_valid && ((r_state != ACCUM) || !w_addr_ok)) || (w_beat && w_ovf);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nxt = ACCUM;
            ACCUM:   if (w_beat && w_last_addr && w_last_ch) w_state_nxt = DRAIN;
            DRAIN:   if (w_last_acc) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_beat) r_map[in_addr] <= w_wr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_ch    <= CH_W'(1);
            r_ch_idx    <= '0;
            r_bias      <= '0;
            r_relu      <= 1'b0;
            r_shift     <= '0;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= w_last_acc;
            if (w_start_ok) begin
                if (cfg_num_ch == '0)                  r_num_ch <= CH_W'(1);
                else if (cfg_num_ch > CH_W'(MAX_CH))   r_num_ch <= CH_W'(MAX_CH);
                else                                   r_num_ch <= cfg_num_ch;
                r_bias   <= cfg_bias;
                r_relu   <= cfg_relu;
                r_shift  <= cfg_shift;
                r_ch_idx <= '0;
                r_ptr    <= '0;
                r_err    <= w_err_evt;
            end else if (w_err_evt) begin
                r_err <= 1'b1;
            end
            if (w_beat && w_last_addr && !w_last_ch) r_ch_idx <= r_ch_idx + 1'b1;
            if (w_load) r_ptr <= r_ptr + 1'b1;
            if (w_load)        r_out_valid <= 1'b1;
            else if (w_accept) r_out_valid <= 1'b0;
        end
    end

    psum_requant #(
        .ACC_W   (ACC_W),
        .OUT_W_Q (OUT_W_Q),
        .AW      (AW)
    ) u_requant (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_acc   (w_rd_acc),
        .i_addr  (r_ptr[AW-1:0]),
        .i_bias  (r_bias),
        .i_relu  (r_relu),
        .i_shift (r_shift),
        .o_data  (out_data),
        .o_addr  (out_addr)
    );

    assign out_valid = r_out_valid;
    assign busy      = r_state != IDLE;
    assign done      = r_done;
    assign ch_idx    = r_ch_idx;
    assign err       = r_err;

endmodule

// File: tb/tb_psum_accum_stream.sv
// Directed + randomised bench for psum_accum_stream against a plain-arithmetic map model.
// A second instance with ACC_W=24 exercises accumulator saturation.
module tb_psum_accum_stream;

    localparam int MAP  = 132;
    localparam int ROWS = 12;
    localparam int COLS = 11;

    logic clk = 1'b0;
    logic rst;
    logic v_start, v_beat, tgt24;
    logic        [4:0]  cfg_num_ch;
    logic signed [31:0] cfg_bias;
    logic signed [23:0] bias_b;
    logic               cfg_relu;
    logic        [4:0]  cfg_shift;
    logic        [7:0]  in_addr;
    logic signed [23:0] in_data;
    logic               out_ready;

    logic start_a, start_b, in_valid_a, in_valid_b;
    logic out_valid_a, busy_a, done_a, err_a, out_valid_b, busy_b, done_b, err_b;
    logic [7:0] out_addr_a, out_addr_b;
    logic signed [7:0] out_data_a, out_data_b;
    logic [4:0] ch_idx_a, ch_idx_b;

    logic m_valid, m_busy, m_done, m_err;
    logic [7:0] m_addr;
    logic signed [7:0] m_data;
    logic [4:0] m_ch;

    assign start_a    = v_start & ~tgt24;
    assign start_b    = v_start &  tgt24;
    assign in_valid_a = v_beat  & ~tgt24;
    assign in_valid_b = v_beat  &  tgt24;
    assign bias_b     = cfg_bias[23:0];
    assign m_valid = tgt24 ? out_valid_b : out_valid_a;
    assign m_busy  = tgt24 ? busy_b : busy_a;
    assign m_done  = tgt24 ? done_b : done_a;
    assign m_err   = tgt24 ? err_b : err_a;
    assign m_addr  = tgt24 ? out_addr_b : out_addr_a;
    assign m_data  = tgt24 ? out_data_b : out_data_a;
    assign m_ch    = tgt24 ? ch_idx_b : ch_idx_a;

    always #5 clk = ~clk;

    psum_accum_stream u_dut (
        .clk(clk), .rst(rst), .start(start_a), .cfg_num_ch(cfg_num_ch), .cfg_bias(cfg_bias),
        .cfg_relu(cfg_relu), .cfg_shift(cfg_shift), .in_valid(in_valid_a), .in_addr(in_addr),
        .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready), .out_addr(out_addr_a),
        .out_data(out_data_a), .busy(busy_a), .done(done_a), .ch_idx(ch_idx_a), .err(err_a)
    );

    psum_accum_stream #(.ACC_W(24)) u_dut24 (
        .clk(clk), .rst(rst), .start(start_b), .cfg_num_ch(cfg_num_ch), .cfg_bias(bias_b),
        .cfg_relu(cfg_relu), .cfg_shift(cfg_shift), .in_valid(in_valid_b), .in_addr(in_addr),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready), .out_addr(out_addr_b),
        .out_data(out_data_b), .busy(busy_b), .done(done_b), .ch_idx(ch_idx_b), .err(err_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: expected accumulator per map cell plus drain configuration.
    longint exp_acc [MAP];
    longint chan    [MAP];
    int     model_ch, accw, shift_m;
    longint bias_m;
    bit     relu_m, exp_err;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint satw(longint v, int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic longint expect_q(int a);
        longint v;
        v = satw(exp_acc[a] + bias_m, accw);
        if (relu_m && v < 0) v = 0;
        v = v >>> shift_m;
        return satw(v, 8);
    endfunction

    task automatic do_start(input int nch, input longint bias, input bit relu, input int shift);
        cfg_num_ch = 5'(nch);
        cfg_bias   = 32'(bias);
        cfg_relu   = relu;
        cfg_shift  = 5'(shift);
        v_start    = 1'b1;
        @(negedge clk);
        v_start    = 1'b0;
        accw = tgt24 ? 24 : 32;
        bias_m = bias; relu_m = relu; shift_m = shift;
        model_ch = 0; exp_err = 0;
    endtask

    task automatic send(input int a, input longint d);
        longint s;
        in_addr = 8'(a);
        in_data = 24'(d);
        v_beat  = 1'b1;
        @(negedge clk);
        v_beat  = 1'b0;
        if (a >= MAP) exp_err = 1;
        else begin
            if (model_ch == 0) exp_acc[a] = d;
            else begin
                s = satw(exp_acc[a] + d, accw);
                if (s != exp_acc[a] + d) exp_err = 1;
                exp_acc[a] = s;
            end
            if (a == MAP - 1) model_ch++;
        end
    endtask

    task automatic send_channel(input bit shuffle, input bit gaps, input bit dups);
        int order[$];
        for (int a = 0; a < MAP - 1; a++) order.push_back(a);
        if (shuffle) begin
            for (int i = MAP - 2; i > 0; i--) begin
                int j, t;
                j = $urandom_range(0, i);
                t = order[i]; order[i] = order[j]; order[j] = t;
            end
        end
        order.push_back(MAP - 1);
        foreach (order[k]) begin
            send(order[k], chan[order[k]]);
            if (dups && order[k] != MAP - 1 && $urandom_range(0, 9) == 0) send(order[k], chan[order[k]]);
            if (gaps && $urandom_range(0, 4) == 0) @(negedge clk);
        end
    endtask

    task automatic drain(input int nbeats, input int low_pct, input bit expect_done);
        int idx = 0, cyc = 0, dones = 0;
        bit held = 0;
        logic [7:0] ha;
        logic signed [7:0] hd;
        while (idx < nbeats && cyc < 3000) begin
            if (held) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_addr", m_addr, ha);
                chk("hold_data", m_data, hd);
            end
            if (m_done) dones++;
            out_ready = ($urandom_range(0, 99) >= low_pct);
            held = 0;
            if (m_valid && out_ready) begin
                chk("out_addr", m_addr, idx);
                chk("out_data", m_data, expect_q(idx));
                idx++;
            end else if (m_valid) begin
                held = 1; ha = m_addr; hd = m_data;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_beats", idx, nbeats);
        if (expect_done) begin
            chk("early_done", dones, 0);
            chk("done_pulse", m_done, 1);
            chk("busy_after", m_busy, 0);
            chk("valid_after", m_valid, 0);
            @(negedge clk);
            chk("done_width", m_done, 0);
        end
    endtask

    initial begin
        longint conv1;
        logic signed [23:0] r24;
        rst = 1'b1; v_start = 0; v_beat = 0; tgt24 = 0; out_ready = 0;
        cfg_num_ch = 0; cfg_bias = 0; cfg_relu = 0; cfg_shift = 0; in_addr = 0; in_data = 0;
        accw = 32; bias_m = 0; relu_m = 0; shift_m = 0; model_ch = 0; exp_err = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", out_valid_a, 0); chk("rst_busy", busy_a, 0); chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0); chk("rst_ch", ch_idx_a, 0); chk("rst_addr", out_addr_a, 0);
        chk("rst_data", out_data_a, 0); chk("rst_valid24", out_valid_b, 0);

        // 1 channel ramp: out = sat8(addr), plus first-output latency
        do_start(1, 0, 0, 0);
        chk("start_busy", m_busy, 1);
        for (int a = 0; a < MAP; a++) chan[a] = a;
        send_channel(0, 0, 0);
        chk("lat1_valid", m_valid, 0);
        @(negedge clk);
        chk("lat2_valid", m_valid, 1);
        chk("ramp_sat_ref", expect_q(130), 127);
        drain(MAP, 0, 1);
        chk("ramp_err", m_err, 0);

        // in_valid in IDLE is dropped and flagged
        in_addr = 8'd3; in_data = 24'd1; v_beat = 1'b1;
        @(negedge clk);
        v_beat = 1'b0;
        chk("idle_beat_err", m_err, 1);
        chk("idle_beat_busy", m_busy, 0);

        // 10 channels of 3x3 conv over a 14x13 ramp, weights (i-1)+(j-1)
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                conv1 = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        conv1 += longint'((r + i) * 13 + (c + j)) * longint'((i - 1) + (j - 1));
                chan[r * COLS + c] = conv1;
            end
        do_start(10, 0, 0, 8);
        chk("start_clears_err", m_err, 0);
        for (int k = 0; k < 10; k++) begin
            send_channel(1, 0, 0);
            if (k < 9) chk("conv_ch_idx", m_ch, k + 1);
        end
        chk("conv_acc_model", exp_acc[0], 10 * chan[0]);
        drain(MAP, 0, 1);

        // ReLU with negative bias, then same map without ReLU
        for (int a = 0; a < MAP; a++) chan[a] = 100;
        for (int p = 0; p < 2; p++) begin
            do_start(5, -1000, (p == 0), 0);
            repeat (5) send_channel(1, 1, 0);
            chk("relu_ref", expect_q(7), (p == 0) ? 0 : -128);
            drain(MAP, 0, 1);
        end

        // Random data, order, duplicates, gaps and 30% stalled ready
        for (int it = 0; it < 3; it++) begin
            do_start($urandom_range(1, 4), longint'($urandom_range(0, 2000000)) - 1000000,
                     1'($urandom_range(0, 1)), $urandom_range(0, 12));
            for (int k = 0; k < model_ch + 5 && model_ch < int'(cfg_num_ch); k++) begin
                for (int a = 0; a < MAP; a++) begin
                    r24 = 24'($urandom);
                    chan[a] = longint'(r24 >>> $urandom_range(0, 16));
                end
                send_channel(1, 1, 1);
            end
            drain(MAP, 30, 1);
            chk("rand_err", m_err, exp_err);
        end

        // ACC_W=24 instance: two max-positive channels saturate
        tgt24 = 1'b1;
        do_start(2, 0, 0, 20);
        for (int a = 0; a < MAP; a++) chan[a] = (1 << 23) - 1;
        send_channel(0, 0, 0);
        send_channel(0, 0, 0);
        chk("sat24_acc_model", exp_acc[5], (1 << 23) - 1);
        chk("sat24_err", m_err, 1);
        drain(MAP, 0, 1);
        tgt24 = 1'b0;

        // start with in_valid in IDLE: beat dropped, err set; rst clears
        cfg_num_ch = 5'd1; in_addr = 8'd5; in_data = 24'd999;
        v_start = 1'b1; v_beat = 1'b1;
        @(negedge clk);
        v_start = 1'b0; v_beat = 1'b0;
        chk("startbeat_busy", m_busy, 1);
        chk("startbeat_err", m_err, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_accum_busy", m_busy, 0);
        chk("rst_accum_err", m_err, 0);

        // Bad address, start while busy, then reset mid-drain
        do_start(2, 3, 0, 1);
        chk("err_clear", m_err, 0);
        send(200, 55);
        chk("bad_addr_err", m_err, 1);
        for (int a = 0; a < MAP; a++) chan[a] = a * 3 - 200;
        send_channel(1, 0, 0);
        chk("busy_ch_before", m_ch, 1);
        cfg_num_ch = 5'd1; v_start = 1'b1;
        @(negedge clk);
        v_start = 1'b0;
        chk("busy_start_ch", m_ch, 1);
        chk("busy_start_busy", m_busy, 1);
        send_channel(1, 0, 0);
        drain(20, 30, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_drain_valid", m_valid, 0);
        chk("rst_drain_busy", m_busy, 0);
        chk("rst_drain_err", m_err, 0);
        for (int i = 0; i < 3; i++) begin
            chk("rst_drain_nodone", m_done, 0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
